// File: rtl/debam_pipe_mult.sv
// debam_pipe_mult: three-stage pipelined DeBAM approximate / exact multiplier.
//   Stage 1 (PPG) decodes B into radix-4 pair terms plus accurate MSB rows,
//   stage 2 (PPR) compresses the rows to sum/carry vectors with a 3:2 chain,
//   stage 3 (CPA) adds sum and carry into the output register.
// Ports:
//   clock, reset_n              rising-edge clock, async active-low reset
//   in_valid/in_ready           operand handshake (in_ready = no output stall)
//   in_a, in_b                  N-bit operands
//   in_exact, in_tag            per-op mode and sideband tag
//   out_valid/out_ready         result handshake
//   out_product                 2N-bit product
//   out_exact, out_tag          mode and tag of the op being presented
//   err_clr, err_count          only with DEBAM_ERR_STAT_EN: approximation
//                               error counter and its synchronous clear
// Optional feature macro: DEBAM_ERR_STAT_EN

module debam_pipe_mult #(
   parameter int unsigned N     = 8,
   parameter int unsigned M     = 2,
   parameter int unsigned TAG_W = 4
`ifdef DEBAM_ERR_STAT_EN
   ,parameter int unsigned CNT_W = 16
`endif
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic             in_exact,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   out_product,
   output logic             out_exact,
   output logic [TAG_W-1:0] out_tag
`ifdef DEBAM_ERR_STAT_EN
   ,input  logic             err_clr
   ,output logic [CNT_W-1:0] err_count
`endif
);

   localparam int unsigned G  = (N - M) / 2;   // number of radix-4 pair groups
   localparam int unsigned R  = G + M;         // rows entering the CSA chain
   localparam int unsigned PW = 2 * N;

   typedef logic [PW-1:0] word_t;

   // Term selected by one B pair; t11 carries the mode-dependent "11" term.
   function automatic word_t pair_term(input logic [1:0] p, input word_t a, input word_t t11);
      word_t t;
      case (p)
         2'b00:   t = '0;
         2'b01:   t = a;
         2'b10:   t = a << 1;
         default: t = t11;
      endcase
      return t;
   endfunction

   logic  stall_c;
   word_t a_ext;

   // A global stall freezes every stage; no bubble collapsing.
   assign stall_c  = out_valid & ~out_ready;
   assign in_ready = ~stall_c;
   assign a_ext    = PW'(in_a);

   // ---------------- stage 1: partial-product generation ----------------
   word_t            pp_d [R];
   word_t            pp_q [R];
   logic             v1_q, ex1_q;
   logic [TAG_W-1:0] tag1_q;

   for (genvar g = 0; g < G; g++) begin : g_grp
      word_t t11;
      // approximate mode replaces A+2A by A|2A, dropping the carry chain
      assign t11     = in_exact ? (a_ext + (a_ext << 1)) : (a_ext | (a_ext << 1));
      assign pp_d[g] = pair_term(in_b[2*g +: 2], a_ext, t11) << (2 * g);
   end

   for (genvar i = 0; i < M; i++) begin : g_msb
      assign pp_d[G+i] = in_b[N-M+i] ? (a_ext << (N - M + i)) : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin : p_stage1
      if (!reset_n) begin
         v1_q   <= 1'b0;
         pp_q   <= '{default: '0};
         ex1_q  <= 1'b0;
         tag1_q <= '0;
      end else if (!stall_c) begin
         v1_q <= in_valid;
         if (in_valid) begin
            pp_q   <= pp_d;
            ex1_q  <= in_exact;
            tag1_q <= in_tag;
         end
      end
   end

   // ---------------- stage 2: carry-save reduction ----------------
   word_t            sum_d, car_d, sum_q, car_q;
   logic             v2_q, ex2_q;
   logic [TAG_W-1:0] tag2_q;

   debam_csa_chain #(.R(R), .W(PW)) u_csa (
      .rows_i  (pp_q),
      .sum_o   (sum_d),
      .carry_o (car_d)
   );

   always_ff @(posedge clock or negedge reset_n) begin : p_stage2
      if (!reset_n) begin
         v2_q   <= 1'b0;
         sum_q  <= '0;
         car_q  <= '0;
         ex2_q  <= 1'b0;
         tag2_q <= '0;
      end else if (!stall_c) begin
         v2_q <= v1_q;
         if (v1_q) begin
            sum_q  <= sum_d;
            car_q  <= car_d;
            ex2_q  <= ex1_q;
            tag2_q <= tag1_q;
         end
      end
   end

   // ---------------- stage 3: carry-propagate add ----------------
   always_ff @(posedge clock or negedge reset_n) begin : p_stage3
      if (!reset_n) begin
         out_valid   <= 1'b0;
         out_product <= '0;
         out_exact   <= 1'b0;
         out_tag     <= '0;
      end else if (!stall_c) begin
         out_valid <= v2_q;
         if (v2_q) begin
            out_product <= sum_q + car_q;
            out_exact   <= ex2_q;
            out_tag     <= tag2_q;
         end
      end
   end

`ifdef DEBAM_ERR_STAT_EN
   // Shadow exact datapath, advancing in lock-step with the main pipe.
   word_t ppx_d [R];
   word_t ppx_q [R];
   word_t sumx_d, carx_d, sumx_q, carx_q, prodx_q;

   for (genvar g = 0; g < G; g++) begin : g_grpx
      assign ppx_d[g] = pair_term(in_b[2*g +: 2], a_ext, a_ext + (a_ext << 1)) << (2 * g);
   end

   for (genvar i = 0; i < M; i++) begin : g_msbx
      assign ppx_d[G+i] = pp_d[G+i];
   end

   debam_csa_chain #(.R(R), .W(PW)) u_csax (
      .rows_i  (ppx_q),
      .sum_o   (sumx_d),
      .carry_o (carx_d)
   );

   always_ff @(posedge clock or negedge reset_n) begin : p_shadow
      if (!reset_n) begin
         ppx_q   <= '{default: '0};
         sumx_q  <= '0;
         carx_q  <= '0;
         prodx_q <= '0;
      end else if (!stall_c) begin
         if (in_valid) ppx_q   <= ppx_d;
         if (v1_q) begin
            sumx_q <= sumx_d;
            carx_q <= carx_d;
         end
         if (v2_q) prodx_q <= sumx_q + carx_q;
      end
   end

   // Count approximate results that differ from exact; clear has priority.
   always_ff @(posedge clock or negedge reset_n) begin : p_err_cnt
      if (!reset_n) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (out_valid && out_ready && !out_exact && (out_product != prodx_q)
                   && (err_count != {CNT_W{1'b1}})) begin
         err_count <= err_count + CNT_W'(1);
      end
   end
`endif

endmodule

// debam_csa_chain: linear 3:2 compressor chain reducing R rows to sum/carry.
// Ports: rows_i (R rows of W bits), sum_o, carry_o (carry already shifted).
// Results are modulo 2^W, which is exact since the product fits in W bits.
module debam_csa_chain #(
   parameter int unsigned R = 5,
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] rows_i [R],
   output logic [W-1:0] sum_o,
   output logic [W-1:0] carry_o
);

   logic [W-1:0] s_c [1:R-1];
   logic [W-1:0] c_c [1:R-1];

   assign s_c[1] = rows_i[0];
   assign c_c[1] = rows_i[1];

   for (genvar i = 2; i < R; i++) begin : g_csa
      assign s_c[i] = s_c[i-1] ^ c_c[i-1] ^ rows_i[i];
      assign c_c[i] = ((s_c[i-1] & c_c[i-1]) | (s_c[i-1] & rows_i[i])
                       | (c_c[i-1] & rows_i[i])) << 1;
   end

   assign sum_o   = s_c[R-1];
   assign carry_o = c_c[R-1];

endmodule
